// File: rtl/sram_port_arbiter_pkg.sv
// Shared CPU package: owner-state encoding and arbiter defaults used by the
// single-port SRAM arbiter and its grant-select sub-module.
package sram_port_arbiter_pkg;

    // Which requester was granted in the previous cycle (owns the SRAM read
    // data returning this cycle).
    typedef enum logic [1:0] {
        OWNER_NONE = 2'd0,
        OWNER_INST = 2'd1,
        OWNER_DATA = 2'd2
    } owner_e;

    // Consecutive denied fetch cycles tolerated before fetch is forced to win.
    localparam int STARVE_MAX_DEFAULT = 4;

    // Width of a counter that must hold values 0..max inclusive.
    function automatic int starve_cnt_width(input int max);
        return (max < 1) ? 1 : $clog2(max + 1);
    endfunction

endpackage : sram_port_arbiter_pkg

// File: rtl/sram_prio_select.sv
// Grant selection between the fetch and memory-stage requesters. Data wins
// by default; fetch wins once it has been denied STARVE_MAX cycles in a row.
// Purely combinational; the two grants are one-hot or both zero.
module sram_prio_select #(
    parameter int CNT_W      = 3,
    parameter int STARVE_MAX = 4
) (
    input  logic             inst_req,
    input  logic             data_req,
    input  logic [CNT_W-1:0] starve_cnt,
    output logic             inst_gnt,
    output logic             data_gnt
);

    logic starved;

    assign starved = (starve_cnt == CNT_W'(STARVE_MAX));

    // Fixed data-over-inst priority with starvation override.
    // NOTE: every output gets a default at the top of the block so no path
    // leaves it unassigned; without that the tool would infer a latch.
    always_comb begin
        inst_gnt = 1'b0;
        data_gnt = 1'b0;
        if (inst_req && (starved || !data_req)) begin
            inst_gnt = 1'b1;
        end else if (data_req) begin
            data_gnt = 1'b1;
        end
    end

endmodule : sram_prio_select

// File: rtl/sram_port_arbiter.sv
// Single-port SRAM arbiter for a CPU fetch port and a memory-stage port.
// Grants are decided combinationally in the request cycle and drive the SRAM
// directly; read data returns one cycle later, steered by the owner register.
module sram_port_arbiter
    import sram_port_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic              inst_gnt,
    output logic              inst_rvalid,
    output logic [DATA_W-1:0] inst_rdata,

    input  logic              data_req,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [3:0]        data_wen,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_gnt,
    output logic              data_rvalid,
    output logic [DATA_W-1:0] data_rdata,

    output logic              sram_en,
    output logic [3:0]        sram_wen,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata
);

    localparam int CNT_W = starve_cnt_width(STARVE_MAX);

    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
    owner_e           owner_q, owner_d;
    logic             inst_req_eff, data_req_eff;

    // Requests are masked while in reset so no grant or SRAM access escapes.
    assign inst_req_eff = inst_req && !reset;
    assign data_req_eff = data_req && !reset;

    sram_prio_select #(
        .CNT_W      (CNT_W),
        .STARVE_MAX (STARVE_MAX)
    ) u_prio_select (
        .inst_req   (inst_req_eff),
        .data_req   (data_req_eff),
        .starve_cnt (starve_cnt_q),
        .inst_gnt   (inst_gnt),
        .data_gnt   (data_gnt)
    );

    // SRAM command mux: the granted requester drives the SRAM, idle is all-zero.
    always_comb begin
        sram_en    = 1'b0;
        sram_wen   = 4'b0000;
        sram_addr  = '0;
        sram_wdata = '0;
        if (inst_gnt) begin
            sram_en   = 1'b1;
            sram_addr = inst_addr;
        end else if (data_gnt) begin
            sram_en    = 1'b1;
            sram_wen   = data_wen;
            sram_addr  = data_addr;
            sram_wdata = data_wdata;
        end
    end

    // Next-state: starvation count saturates while fetch waits, clears otherwise;
    // owner records this cycle's grant for next cycle's completion.
    always_comb begin
        starve_cnt_d = '0;
        if (inst_req_eff && !inst_gnt) begin
            starve_cnt_d = (starve_cnt_q == CNT_W'(STARVE_MAX))
                         ? starve_cnt_q
                         : starve_cnt_q + CNT_W'(1);
        end

        owner_d = OWNER_NONE;
        if (inst_gnt) begin
            owner_d = OWNER_INST;
        end else if (data_gnt) begin
            owner_d = OWNER_DATA;
        end
    end

    // State registers with synchronous reset.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt_q <= '0;
            owner_q      <= OWNER_NONE;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            owner_q      <= owner_d;
        end
    end

    // Completion signalling: fixed one-cycle latency from grant. Gated by reset
    // so an access granted just before reset never reports completion.
    assign inst_rvalid = (owner_q == OWNER_INST) && !reset;
    assign data_rvalid = (owner_q == OWNER_DATA) && !reset;
    assign inst_rdata  = sram_rdata;
    assign data_rdata  = sram_rdata;

endmodule : sram_port_arbiter

// File: tb/tb_sram_port_arbiter.sv
// Self-checking bench for sram_port_arbiter: per-cycle stimulus with expected
// grants; expected completions are queued at grant time and popped one cycle
// later when the DUT should signal rvalid.
module tb_sram_port_arbiter;
    import sram_port_arbiter_pkg::*;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              inst_req;
    logic [ADDR_W-1:0] inst_addr;
    logic              inst_gnt, inst_rvalid;
    logic [DATA_W-1:0] inst_rdata;
    logic              data_req;
    logic [ADDR_W-1:0] data_addr;
    logic [3:0]        data_wen;
    logic [DATA_W-1:0] data_wdata;
    logic              data_gnt, data_rvalid;
    logic [DATA_W-1:0] data_rdata;
    logic              sram_en;
    logic [3:0]        sram_wen;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_wdata;
    logic [DATA_W-1:0] sram_rdata;

    always #5 clk = ~clk;

    sram_port_arbiter #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .STARVE_MAX (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .inst_req    (inst_req),
        .inst_addr   (inst_addr),
        .inst_gnt    (inst_gnt),
        .inst_rvalid (inst_rvalid),
        .inst_rdata  (inst_rdata),
        .data_req    (data_req),
        .data_addr   (data_addr),
        .data_wen    (data_wen),
        .data_wdata  (data_wdata),
        .data_gnt    (data_gnt),
        .data_rvalid (data_rvalid),
        .data_rdata  (data_rdata),
        .sram_en     (sram_en),
        .sram_wen    (sram_wen),
        .sram_addr   (sram_addr),
        .sram_wdata  (sram_wdata),
        .sram_rdata  (sram_rdata)
    );

    typedef struct {
        logic inst;
        logic data;
    } comp_t;

    comp_t sb_q[$];
    int    n_checks = 0;
    int    n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock cycle: called at posedge+1, drives inputs, checks at negedge,
    // returns at the following posedge+1.
    task automatic step(input string tag, input logic rst,
                        input logic ireq, input logic [ADDR_W-1:0] iaddr,
                        input logic dreq, input logic [ADDR_W-1:0] daddr,
                        input logic [3:0] dwen, input logic [DATA_W-1:0] dwdata,
                        input logic exp_ig, input logic exp_dg);
        comp_t exp_c;
        logic [DATA_W-1:0] rd;
        rd         = $urandom;
        reset      = rst;
        inst_req   = ireq;
        inst_addr  = iaddr;
        data_req   = dreq;
        data_addr  = daddr;
        data_wen   = dwen;
        data_wdata = dwdata;
        sram_rdata = rd;

        exp_c = '{inst: 1'b0, data: 1'b0};
        if (sb_q.size() > 0) exp_c = sb_q.pop_front();
        if (rst) exp_c = '{inst: 1'b0, data: 1'b0};

        @(negedge clk);
        check({tag, ".inst_gnt"}, 64'(inst_gnt), 64'(exp_ig));
        check({tag, ".data_gnt"}, 64'(data_gnt), 64'(exp_dg));
        check({tag, ".sram_en"},  64'(sram_en),  64'(exp_ig | exp_dg));
        check({tag, ".sram_addr"}, 64'(sram_addr),
              exp_ig ? 64'(iaddr) : exp_dg ? 64'(daddr) : 64'd0);
        check({tag, ".sram_wen"}, 64'(sram_wen), exp_dg ? 64'(dwen) : 64'd0);
        check({tag, ".sram_wdata"}, 64'(sram_wdata), exp_dg ? 64'(dwdata) : 64'd0);
        check({tag, ".inst_rvalid"}, 64'(inst_rvalid), 64'(exp_c.inst));
        check({tag, ".data_rvalid"}, 64'(data_rvalid), 64'(exp_c.data));
        if (exp_c.inst) check({tag, ".inst_rdata"}, 64'(inst_rdata), 64'(rd));
        if (exp_c.data) check({tag, ".data_rdata"}, 64'(data_rdata), 64'(rd));
        check({tag, ".rvalid_excl"}, 64'(inst_rvalid & data_rvalid), 64'd0);

        sb_q.push_back('{inst: exp_ig, data: exp_dg});
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, 1'b0, '0, 1'b0, '0, 4'b0000, '0, 1'b0, 1'b0);
    endtask

    task automatic both(input string tag, input logic exp_ig, input logic exp_dg);
        step(tag, 1'b0, 1'b1, 32'h0000_2000, 1'b1, 32'h0000_3000, 4'b0000, '0, exp_ig, exp_dg);
    endtask

    initial begin
        reset = 1'b1; inst_req = 1'b0; inst_addr = '0; data_req = 1'b0;
        data_addr = '0; data_wen = '0; data_wdata = '0; sram_rdata = '0;
        @(posedge clk); #1;

        // Reset with requests present: nothing granted, nothing completes.
        step("rst0", 1'b1, 1'b1, 32'h40, 1'b1, 32'h80, 4'b1111, 32'h1234, 1'b0, 1'b0);
        step("rst1", 1'b1, 1'b0, '0, 1'b0, '0, 4'b0000, '0, 1'b0, 1'b0);
        check("rst.starve_cnt", 64'(dut.starve_cnt_q), 64'd0);
        check("rst.owner", 64'(dut.owner_q), 64'(OWNER_NONE));

        // Idle for three cycles.
        idle("idle0"); idle("idle1"); idle("idle2");

        // Single load then its completion.
        step("load", 1'b0, 1'b0, '0, 1'b1, 32'h100, 4'b0000, '0, 1'b0, 1'b1);
        idle("load_done");

        // Store then its acknowledge.
        step("store", 1'b0, 1'b0, '0, 1'b1, 32'h204, 4'b0011, 32'hDEAD_BEEF, 1'b0, 1'b1);
        idle("store_done");

        // Contention for six cycles: starvation override at cycle 4.
        both("cont0", 1'b0, 1'b1);
        both("cont1", 1'b0, 1'b1);
        both("cont2", 1'b0, 1'b1);
        both("cont3", 1'b0, 1'b1);
        check("cont.starve_sat", 64'(dut.starve_cnt_q), 64'd4);
        both("cont4", 1'b1, 1'b0);
        check("cont.starve_clr", 64'(dut.starve_cnt_q), 64'd0);
        both("cont5", 1'b0, 1'b1);
        idle("cont_drain");

        // Starve count clears when fetch withdraws.
        both("wd0", 1'b0, 1'b1);
        both("wd1", 1'b0, 1'b1);
        step("wd2", 1'b0, 1'b0, '0, 1'b1, 32'h300, 4'b0000, '0, 1'b0, 1'b1);
        check("wd.starve_clr", 64'(dut.starve_cnt_q), 64'd0);
        idle("wd_drain");

        // Back-to-back inst then data grants, no bubble.
        step("b2b0", 1'b0, 1'b1, 32'h500, 1'b0, '0, 4'b0000, '0, 1'b1, 1'b0);
        step("b2b1", 1'b0, 1'b0, '0, 1'b1, 32'h600, 4'b1100, 32'hCAFE_F00D, 1'b0, 1'b1);
        idle("b2b2");

        // Reset mid-operation: granted data access must not complete.
        step("mrst0", 1'b0, 1'b0, '0, 1'b1, 32'h700, 4'b0000, '0, 1'b0, 1'b1);
        step("mrst1", 1'b1, 1'b0, '0, 1'b0, '0, 4'b0000, '0, 1'b0, 1'b0);
        check("mrst.owner", 64'(dut.owner_q), 64'(OWNER_NONE));
        // First grant possible in the first cycle out of reset.
        step("mrst2", 1'b0, 1'b1, 32'h800, 1'b0, '0, 4'b0000, '0, 1'b1, 1'b0);
        idle("mrst3");
        idle("end");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_sram_port_arbiter

// File: doc/sram_port_arbiter.md
SRAM_PORT_ARBITER -- requirements
Module: sram_port_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32: address width of all requester and SRAM address ports.
REQ-002 Parameter DATA_W, default 32: data width of all write and read data ports.
REQ-003 Parameter STARVE_MAX, default 4: maximum consecutive denied cycles for the fetch port before it is forced to win.
REQ-004 Port clk, input, 1: single clock; all state SHALL update on its rising edge.
REQ-005 Port reset, input, 1: synchronous, active-high reset.
REQ-006 Port inst_req, input, 1: fetch read request; held until inst_gnt.
REQ-007 Port inst_addr, input, ADDR_W: fetch address.
REQ-008 Port inst_gnt, output, 1: fetch request accepted this cycle.
REQ-009 Port inst_rvalid, output, 1: inst_rdata valid this cycle.
REQ-010 Port inst_rdata, output, DATA_W: fetch read data.
REQ-011 Port data_req, input, 1: memory-stage request (load or store); held until data_gnt.
REQ-012 Port data_addr, input, ADDR_W: memory-stage address.
REQ-013 Port data_wen, input, 4: byte write enables; 4'b0000 means read.
REQ-014 Port data_wdata, input, DATA_W: store data.
REQ-015 Port data_gnt, output, 1: memory-stage request accepted this cycle.
REQ-016 Port data_rvalid, output, 1: completion pulse; carries load data, and acknowledges a store.
REQ-017 Port data_rdata, output, DATA_W: load data.
REQ-018 Port sram_en, output, 1: SRAM enable.
REQ-019 Port sram_wen, output, 4: SRAM byte write enables.
REQ-020 Port sram_addr, output, ADDR_W: SRAM address.
REQ-021 Port sram_wdata, output, DATA_W: SRAM write data.
REQ-022 Port sram_rdata, input, DATA_W: SRAM read data, valid one cycle after the access.

Function
REQ-023 Grant decision SHALL be combinational in the request cycle; at most one of inst_gnt and data_gnt SHALL be high per cycle.
REQ-024 Priority SHALL be data over inst, except when starve_cnt equals STARVE_MAX, in which case inst SHALL win.
REQ-025 starve_cnt SHALL increment, saturating at STARVE_MAX, on every cycle in which inst_req=1 and inst_gnt=0.
REQ-026 starve_cnt SHALL clear on any cycle with inst_gnt=1 or inst_req=0.
REQ-027 SRAM ports SHALL be driven from the granted requester in the grant cycle:
- sram_en=1.
- For fetch, sram_wen=0.
- When no request is granted, sram_en=0, and sram_wen, sram_addr and sram_wdata SHALL be 0.
REQ-028 Owner register SHALL use states NONE, INST and DATA, recording the port granted in the previous cycle.
REQ-029 Owner transitions SHALL occur every cycle:
- Next state is INST on inst_gnt.
- Next state is DATA on data_gnt.
- Next state is NONE otherwise.
REQ-030 inst_rvalid SHALL equal (owner==INST), and data_rvalid SHALL equal (owner==DATA), giving a fixed latency of one cycle from grant.
REQ-031 inst_rdata and data_rdata SHALL both pass sram_rdata directly; they are meaningful only when the matching rvalid is high.
REQ-032 Back-to-back grants SHALL be supported, one per cycle, with no bubble, including a switch between ports.
REQ-033 When a grant and a completion occur in the same cycle, both SHALL be signalled independently.

Reset
REQ-034 While reset=1, the block SHALL force owner=NONE and starve_cnt=0, and all gnt, rvalid and sram_en outputs SHALL be 0.
REQ-035 An access granted in the cycle before reset asserts SHALL produce no rvalid.
REQ-036 The first grant SHALL be possible in the first cycle with reset=0.

Structure
REQ-037 The owner-state enumeration (NONE, INST, DATA) and the default STARVE_MAX SHALL live in the shared CPU package.
REQ-038 The grant logic SHALL be a sub-module, sram_prio_select, that takes both requests and starve_cnt and returns the two one-hot grants.

Verification
REQ-039 Single load: data_req=1, addr=0x100, wen=0.
- Response: data_gnt in cycle 0, sram_addr=0x100, sram_en=1.
- Cycle 1: data_rvalid=1, data_rdata=sram_rdata.
REQ-040 Store: data_wen=4'b0011, wdata=0xDEADBEEF.
- Cycle 0: sram_wen=4'b0011, sram_wdata=0xDEADBEEF.
- Cycle 1: data_rvalid=1.
REQ-041 Contention: both requests held for 6 cycles, with STARVE_MAX=4.
- Cycles 0-3: data_gnt.
- Cycle 4: inst_gnt.
- Cycle 5: data_gnt.
- starve_cnt SHALL read 0 after cycle 4.
REQ-042 Back-to-back: inst grant at cycle 0, then data grant at cycle 1.
- Cycle 1: inst_rvalid.
- Cycle 2: data_rvalid.
- Never both rvalids in one cycle.
REQ-043 Reset mid-operation: data granted at cycle 0, reset=1 at cycle 1.
- data_rvalid SHALL stay 0.
- Owner SHALL be NONE.
REQ-044 Idle: no requests for 3 cycles; sram_en, both gnt and both rvalid SHALL be 0 throughout.
